// File: rtl/load_unit.sv
// Load unit: queues load requests, issues them one at a time to memd, and
// broadcasts each result with its tag on a registered write-back port.
module load_unit #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic                    flush,
    output logic                    mem_valid,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    input  logic                    mem_data_valid,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    wb_valid,
    output logic [TAG_W-1:0]        wb_tag,
    output logic [DATA_W-1:0]       wb_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [ADDR_W-1:0]   addr_mem_r [DEPTH];
    logic [TAG_W-1:0]    tag_mem_r  [DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;

    logic [ADDR_W-1:0]   inflight_addr_r;
    logic [TAG_W-1:0]    inflight_tag_r;

    logic                wb_valid_r;
    logic [TAG_W-1:0]    wb_tag_r;
    logic [DATA_W-1:0]   wb_data_r;

    logic                req_ready_s;
    logic                push_s;
    logic                issue_s;
    logic                wb_accept_s;

    // Full blocks acceptance even when a pop happens in the same cycle.
    assign req_ready_s = (count_r < DEPTH_C);
    assign push_s      = req_valid && req_ready_s && !flush;
    // memd raises ready in its output cycle, so a WAIT load can hand over back-to-back.
    assign issue_s     = !flush && mem_ready && (count_r != {CNT_W{1'b0}}) &&
                         ((state_r == ST_IDLE) || ((state_r == ST_WAIT) && mem_data_valid));
    assign wb_accept_s = (state_r == ST_WAIT) && mem_data_valid && !flush;

    assign req_ready = req_ready_s;
    assign mem_valid = issue_s;
    // Hold the in-flight address: memd's countdown keeps reading in_addr.
    assign mem_addr  = issue_s ? addr_mem_r[head_r] : inflight_addr_r;
    assign count     = count_r;
    assign wb_valid  = wb_valid_r;
    assign wb_tag    = wb_tag_r;
    assign wb_data   = wb_data_r;

    // Request FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                tag_mem_r[i]  <= {TAG_W{1'b0}};
            end
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= req_addr;
                tag_mem_r[tail_r]  <= req_tag;
                tail_r             <= tail_r + PTR_W'(1);
            end
            if (issue_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, issue_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state logic for the single-outstanding-load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) state_nxt_s = ST_WAIT;
                else         state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (mem_data_valid) begin
                    if (issue_s) state_nxt_s = ST_WAIT;
                    else         state_nxt_s = ST_IDLE;
                end else if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mem_data_valid) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, in-flight record and registered write-back port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            inflight_addr_r <= {ADDR_W{1'b0}};
            inflight_tag_r  <= {TAG_W{1'b0}};
            wb_valid_r      <= 1'b0;
            wb_tag_r        <= {TAG_W{1'b0}};
            wb_data_r       <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                inflight_addr_r <= addr_mem_r[head_r];
                inflight_tag_r  <= tag_mem_r[head_r];
            end
            if (wb_accept_s) begin
                wb_valid_r <= 1'b1;
                wb_tag_r   <= inflight_tag_r;
                wb_data_r  <= mem_data;
            end else begin
                wb_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/load_unit.md
# load_unit

Load unit sitting directly upstream of the data memory stage (`memd`). It queues load requests from the issue stage in a small FIFO and issues them to `memd` one at a time over its ready/valid port. It waits out `memd`'s address-dependent latency, then broadcasts each result with its tag on a registered write-back port. Loads complete in program order, and a flush squashes queued and in-flight loads.

## Interface
Parameters:
- `ADDR_W`, default 2: memory address width; must equal the `memd` address width (`MEMD_SIZE`).
- `DATA_W`, default 8: data width; must equal `REG_LEN`.
- `TAG_W`, default 3: destination tag width (ROB/physical register tag).
- `DEPTH`, default 4: request FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  issue stage offers a load.
- `req_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `req_addr`  in  ADDR_W  load address.
- `req_tag`  in  TAG_W  destination tag.
- `flush`  in  1  squash all queued and in-flight loads.
- `mem_valid`  out  1  drives `memd` `in_valid`.
- `mem_addr`  out  ADDR_W  drives `memd` `in_addr`.
- `mem_ready`  in  1  from `memd` `ready`.
- `mem_data_valid`  in  1  from `memd` `out_valid`.
- `mem_data`  in  DATA_W  from `memd` `out_data`.
- `wb_valid`  out  1  one-cycle write-back pulse.
- `wb_tag`  out  TAG_W  tag of the completed load.
- `wb_data`  out  DATA_W  loaded data.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO:** head/tail pointers wrap modulo DEPTH.
  - Push on `req_valid && req_ready && !flush`.
  - Pop on issue.
  - A simultaneous push and pop leaves `count` unchanged.
  - `req_ready` is 0 when full, even if a pop happens the same cycle.
- **FSM states:** IDLE, WAIT (one load in flight), DRAIN (squashed load in flight).
- **`issue` (combinational):** `!flush && mem_ready && count != 0 && (state==IDLE || (state==WAIT && mem_data_valid))`.
  - `mem_valid = issue`.
  - On issue, the head addr/tag are latched into `inflight_addr` and `inflight_tag`.
- **`mem_addr`:** the head address when `issue`, otherwise `inflight_addr`.
  - The held address must stay stable while a load is outstanding, because `memd`'s countdown depends on its `in_addr` input.
- **Transitions:**
  - IDLE → WAIT on `issue`.
  - WAIT + `mem_data_valid`: capture the write-back. Next state is WAIT if `issue`, else IDLE. Back-to-back issue in the response cycle is legal because `memd` reports ready in its output cycle.
  - WAIT + `flush` without `mem_data_valid` → DRAIN.
  - WAIT + `flush` with `mem_data_valid` → IDLE; the response is discarded.
  - DRAIN + `mem_data_valid` → IDLE; data discarded, no issue that cycle.
  - DRAIN ignores `flush`.
- **Flush:** the FIFO empties next cycle (`count` = 0). The request offered in the flush cycle is dropped. Requests pushed during DRAIN are kept.
- **`mem_data_valid` in IDLE:** spurious; ignored.

## Timing
- **Write-back:**
  - `wb_valid`, `wb_tag` and `wb_data` are registered.
  - `wb_valid` is 1 for exactly the one cycle after an accepted (non-squashed) `mem_data_valid`; otherwise 0.
  - `wb_tag` and `wb_data` hold their last values while `wb_valid` is 0.
- **Latency:**
  - Request accepted at cycle T is at the FIFO head at T+1 and issues at T+1 at the earliest.
  - `memd` with address a returns data at issue+a+1; `wb_valid` follows one cycle later.
  - Address-0 minimum: request at T gives write-back at T+3.
- **Reset:** state IDLE, pointers and `count` 0, `inflight_addr`/`inflight_tag` 0. Outputs `wb_valid`, `wb_tag`, `wb_data` and `mem_valid` are 0, and `mem_addr` is 0; `req_ready` is 1. Reset mid-operation abandons all loads; `memd` is reset by the same `rst`.
- **Throughput:** at most one load in flight; one load per (a+1) cycles when back-to-back.

## Test plan
- `memd` initialised {2,3,3,3}. Request addr 0, tag 5 at cycle 0 → `mem_valid` at cycle 1 with `mem_addr`=0; `wb_valid` at cycle 3 with tag 5, data 2; no further pulses.
- Push addr 3/tag 1 then addr 1/tag 2 on consecutive cycles → second issue lands in the same cycle as the first `mem_data_valid`. Write-backs arrive as tag 1 / data 3, then tag 2 / data 3, in that order. `mem_addr` holds 3 throughout the first wait.
- With addr 3 in flight, push 5 requests → `count` reaches 4, `req_ready`=0, and the 5th request is not accepted. All 4 complete in order with correct tags; `count` returns to 0.
- Issue addr 3 / tag 1, assert `flush` 2 cycles later, then push addr 0 / tag 7 → no write-back for tag 1. Tag 7 issues only after the discarded response, and its write-back carries data 2.
- `flush` in the same cycle as `mem_data_valid` plus a `req_valid` → no write-back, request dropped, state IDLE, `count` 0.
- Assert `rst` while in WAIT with 3 queued → next cycle all outputs are at reset values and `count`=0; a subsequent addr 2 load writes back data 3.
